// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against
// out-of-order long-latency results, tracks pending destinations, bounds MDU starvation.
module rf_wb_scheduler #(
    parameter int WIDTH    = 32,
    parameter int NREG     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_wr_en,
    input  logic [$clog2(NREG)-1:0]  pipe_addr,
    input  logic [WIDTH-1:0]         pipe_data,
    input  logic                     mdu_valid,
    input  logic [$clog2(NREG)-1:0]  mdu_addr,
    input  logic [WIDTH-1:0]         mdu_data,
    output logic                     mdu_ready,
    input  logic                     issue_valid,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic [$clog2(NREG)-1:0]  dec_rs1,
    input  logic [$clog2(NREG)-1:0]  dec_rs2,
    input  logic [$clog2(NREG)-1:0]  dec_rd,
    input  logic                     dec_rs1_used,
    input  logic                     dec_rs2_used,
    input  logic                     dec_rd_used,
    output logic                     hazard_stall,
    output logic                     pipe_hold,
    output logic                     rf_wr_en,
    output logic [$clog2(NREG)-1:0]  rf_addr,
    output logic [WIDTH-1:0]         rf_data
);

    localparam int AW = $clog2(NREG);
    localparam int CW = 4;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [CW-1:0]   wait_cnt_q;
    logic [CW-1:0]   wait_cnt_d;

    logic sel_pipe;
    logic sel_mdu;
    logic set_en;
    logic clr_en;

    // Write-port arbitration; every output is forced low while reset is held.
    always_comb begin
        pipe_hold = 1'b0;
        sel_pipe  = 1'b0;
        sel_mdu   = 1'b0;
        mdu_ready = 1'b0;
        rf_wr_en  = 1'b0;
        rf_addr   = '0;
        rf_data   = '0;
        if (reset) begin
            pipe_hold = mdu_valid && (wait_cnt_q == WAIT_LIMIT);
            if (pipe_hold) begin
                sel_mdu = 1'b1;
            end else if (pipe_wr_en) begin
                sel_pipe = 1'b1;
            end else if (mdu_valid) begin
                sel_mdu = 1'b1;
            end
            if (sel_pipe) begin
                rf_addr  = pipe_addr;
                rf_data  = pipe_data;
                rf_wr_en = (pipe_addr != '0);
            end else if (sel_mdu) begin
                mdu_ready = mdu_valid;
                rf_addr   = mdu_addr;
                rf_data   = mdu_data;
                rf_wr_en  = mdu_valid && (mdu_addr != '0);
            end
        end
    end

    // Consecutive-refusal counter; saturates so pipe_hold stays up until the MDU retires.
    always_comb begin
        wait_cnt_d = '0;
        if (mdu_valid && !mdu_ready) begin
            if (wait_cnt_q == WAIT_LIMIT) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        set_en    = issue_valid && (issue_rd != '0);
        clr_en    = mdu_valid && mdu_ready && (mdu_addr != '0);
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[mdu_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        hazard_stall = (dec_rs1_used && pending_q[dec_rs1])
                     | (dec_rs2_used && pending_q[dec_rs2])
                     | (dec_rd_used  && pending_q[dec_rd]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Schedules the register file's single write port between two sources: the in-order pipeline writeback, and a long-latency unit (MDU/CSR) that returns results out of order.
- Keeps a per-register pending scoreboard so decode stalls on RAW/WAW hazards against outstanding long-latency results.
- Bounds MDU starvation with a pipeline-freeze request.
- Sits between writeback, decode and the register file write port.

Parameters:
- WIDTH, 32, data width of register file entries.
- NREG, 32, number of architectural registers; address width is $clog2(NREG).
- MAX_WAIT, 4, maximum consecutive cycles an MDU result may be refused before pipe_hold asserts (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low.
- pipe_wr_en  input  1  pipeline writeback valid this cycle.
- pipe_addr  input  5  pipeline destination register.
- pipe_data  input  WIDTH  pipeline writeback data.
- mdu_valid  input  1  MDU result available.
- mdu_addr  input  5  MDU destination register.
- mdu_data  input  WIDTH  MDU result.
- mdu_ready  output  1  MDU result accepted this cycle.
- issue_valid  input  1  long-latency instruction dispatched this cycle.
- issue_rd  input  5  its destination register.
- dec_rs1, dec_rs2, dec_rd  input  5 each  source and destination registers of the instruction in decode.
- dec_rs1_used, dec_rs2_used, dec_rd_used  input  1 each  qualify the corresponding field.
- hazard_stall  output  1  decode must hold its instruction.
- pipe_hold  output  1  pipeline must freeze; no pipeline writeback this cycle.
- rf_wr_en  output  1  register file write enable.
- rf_addr  output  5  register file write address.
- rf_data  output  WIDTH  register file write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - pending[NREG-1:0] = 0, wait_cnt = 0.
  - All outputs 0: rf_wr_en=0, mdu_ready=0, hazard_stall=0, pipe_hold=0.
- Write-port arbitration (combinational, same cycle):
  - pipe_hold=0: the pipeline has priority. If pipe_wr_en=1, rf_* = pipe_*, mdu_ready=0. Otherwise, if mdu_valid=1, rf_* = mdu_*, mdu_ready=1.
  - pipe_hold=1: rf_* = mdu_*, mdu_ready=mdu_valid. pipe_wr_en=1 while pipe_hold=1 is a protocol violation; the bench flags it. The pipeline write is not performed.
  - Any selected write with address 0: rf_wr_en=0. The MDU handshake still completes (mdu_ready=1) and clears nothing.
- Starvation counter:
  - wait_cnt increments when mdu_valid && !mdu_ready, saturating at MAX_WAIT.
  - wait_cnt clears when mdu_ready=1 or mdu_valid=0.
  - pipe_hold = (wait_cnt == MAX_WAIT) && mdu_valid. An MDU result therefore waits at most MAX_WAIT cycles and retires in cycle MAX_WAIT+1.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the next edge.
  - Clear: mdu_valid && mdu_ready && mdu_addr!=0 clears pending[mdu_addr] at the next edge.
  - Set and clear of the same register in the same cycle: set wins (new producer outstanding).
  - pending[0] is never set.
- Hazard detection (combinational from registered pending):
  - hazard_stall = (rs1_used && pending[rs1]) | (rs2_used && pending[rs2]) | (rd_used && pending[rd]).
  - The same-cycle MDU retirement does not release the stall; release occurs the cycle after clear (no forwarding).
- Issuing to a register that is already pending cannot occur: the WAW term stalls it in decode.
- Reset mid-operation clears pending and wait_cnt immediately. In-flight MDU results after reset are accepted normally and write the register file.

Test Plan:
- Reset: hold reset=0 with mdu_valid=1, pipe_wr_en=1 -> rf_wr_en=0, mdu_ready=0, hazard_stall=0, pipe_hold=0; after release, pending=0.
- Scoreboard RAW: issue_valid, issue_rd=5; next cycle dec_rs1=5, used -> hazard_stall=1. MDU returns addr 5, data 0xDEADBEEF -> rf_wr_en=1, rf_addr=5, rf_data=0xDEADBEEF, mdu_ready=1; hazard_stall=0 the following cycle.
- Priority: same cycle pipe_wr_en (addr 3, 0x11) and mdu_valid (addr 7, 0x22) -> rf_addr=3, mdu_ready=0. Next cycle with pipe idle -> rf_addr=7, mdu_ready=1.
- Starvation: mdu_valid held, pipe_wr_en=1 every cycle, MAX_WAIT=4 -> mdu_ready=0 for 4 cycles; pipe_hold=1 in cycle 5 with mdu_ready=1; wait_cnt=0 after.
- x0: mdu_valid with addr 0 -> mdu_ready=1, rf_wr_en=0. issue_rd=0 -> no stall on dec_rs1=0.
- Set/clear collision: MDU retires r9 while issue_valid with issue_rd=9 -> pending[9] remains 1; dec_rs2=9 stalls.
